// File: rtl/uart_pkg.sv
// uart_pkg: definitions shared by the UART transmitter and the planned
// receiver.
//   uart_state_e          frame FSM state encoding
//   PARITY_NONE/ODD/EVEN  values for the PARITY parameter
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_e;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_ODD  = 1;
  localparam int PARITY_EVEN = 2;

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO. The head word is presented combinationally
// on rdata.
//   clk    rising-edge clock
//   rst_n  synchronous active-low reset; clears pointers and occupancy
//   push   write request; ignored while full (even with a pop in the same cycle)
//   wdata  word written on an accepted push
//   pop    read request; ignored while empty
//   rdata  current head word
//   full   registered, occupancy == DEPTH
//   empty  registered, occupancy == 0
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_nxt;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  always_comb begin
    count_nxt = count;
    case ({do_push, do_pop})
      2'b10:   count_nxt = count + 1'b1;
      2'b01:   count_nxt = count - 1'b1;
      default: count_nxt = count;
    endcase
  end

  // Storage carries no reset; only the bookkeeping is cleared.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count_nxt;
      full  <= (count_nxt == CNT_FULL);
      empty <= (count_nxt == '0);
    end
  end

endmodule

// File: rtl/uart_tx_param.sv
// uart_tx_param: buffered, parameterised UART transmitter.
//   i_clk        rising-edge clock
//   i_rst_n      synchronous active-low reset; aborts any frame, flushes the FIFO
//   i_wr/i_data  write port
//   o_full       registered, FIFO holds FIFO_DEPTH words
//   o_busy       registered, FIFO non-empty or a frame in progress
//   o_uart_tx    registered serial line, idle high
//   o_dbg_state  current FSM state, for observation only
//
// Write handshake: i_wr acts as valid and !o_full as ready. A word is taken
// on a rising edge where i_wr=1 and o_full=0; a word offered while o_full=1 is
// dropped, not held. Every cycle with i_wr=1 offers a new word.
module uart_tx_param
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 1302,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = PARITY_NONE,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_wr,
  input  logic [DATA_BITS-1:0] i_data,
  output logic                 o_full,
  output logic                 o_busy,
  output logic                 o_uart_tx,
  output uart_state_e          o_dbg_state
);

  localparam int BAUD_W = $clog2(CLKS_PER_BIT);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [3:0] DATA_LAST = 4'(DATA_BITS - 1);
  localparam logic [3:0] STOP_LAST = 4'(STOP_BITS - 1);

  uart_state_e          state;
  logic [BAUD_W-1:0]    baud_cnt;
  logic [3:0]           bit_cnt;
  logic [DATA_BITS-1:0] shreg;
  logic                 par_bit;
  logic                 fifo_empty;
  logic [DATA_BITS-1:0] fifo_head;
  logic                 bit_end;
  logic                 stop_end;
  logic                 pop;

  assign bit_end  = (baud_cnt == BAUD_LAST);
  assign stop_end = (state == ST_STOP) && bit_end && (bit_cnt == STOP_LAST);
  // Load a new word from IDLE, or straight from the last stop cycle so that
  // consecutive frames have no idle gap.
  assign pop = !fifo_empty && ((state == ST_IDLE) || stop_end);

  sync_fifo #(
    .WIDTH(DATA_BITS),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk  (i_clk),
    .rst_n(i_rst_n),
    .push (i_wr),
    .wdata(i_data),
    .pop  (pop),
    .rdata(fifo_head),
    .full (o_full),
    .empty(fifo_empty)
  );

  assign o_dbg_state = state;

  // The line is registered from the current state, so it trails the state
  // register by one cycle. Every bit keeps its full length; only the
  // whole frame shifts, which gives the two-edge write-to-start latency.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state     <= ST_IDLE;
      baud_cnt  <= '0;
      bit_cnt   <= '0;
      shreg     <= '0;
      par_bit   <= 1'b0;
      o_uart_tx <= 1'b1;
      o_busy    <= 1'b0;
    end else begin
      o_busy <= 1'b1;
      case (state)
        ST_START:  o_uart_tx <= 1'b0;
        ST_DATA:   o_uart_tx <= shreg[0];
        ST_PARITY: o_uart_tx <= par_bit;
        default:   o_uart_tx <= 1'b1;
      endcase

      case (state)
        ST_IDLE: begin
          baud_cnt <= '0;
          bit_cnt  <= '0;
          o_busy   <= !fifo_empty;
          if (!fifo_empty) begin
            shreg   <= fifo_head;
            par_bit <= (PARITY == PARITY_ODD) ? ~(^fifo_head) : (^fifo_head);
            state   <= ST_START;
          end
        end
        ST_START: begin
          if (bit_end) begin
            baud_cnt <= '0;
            bit_cnt  <= '0;
            state    <= ST_DATA;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        ST_DATA: begin
          if (bit_end) begin
            baud_cnt <= '0;
            shreg    <= shreg >> 1;
            if (bit_cnt == DATA_LAST) begin
              bit_cnt <= '0;
              state   <= (PARITY != PARITY_NONE) ? ST_PARITY : ST_STOP;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        ST_PARITY: begin
          if (bit_end) begin
            baud_cnt <= '0;
            bit_cnt  <= '0;
            state    <= ST_STOP;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        ST_STOP: begin
          if (bit_end) begin
            baud_cnt <= '0;
            if (bit_cnt == STOP_LAST) begin
              bit_cnt <= '0;
              if (!fifo_empty) begin
                shreg   <= fifo_head;
                par_bit <= (PARITY == PARITY_ODD) ? ~(^fifo_head) : (^fifo_head);
                state   <= ST_START;
              end else begin
                o_busy <= 1'b0;
                state  <= ST_IDLE;
              end
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_param.sv
// tb_uart_tx_param: directed bench for uart_tx_param. Four instances cover
// 8N1, 8E1, 8O1 and 7N2 at four clocks per bit, sharing clock and reset.
module tb_uart_tx_param;
  import uart_pkg::*;

  localparam int C = 4;

  typedef struct {
    int          dut;
    logic [8:0]  data;
    logic [12:0] frame;   // bit i = i-th bit on the line, start bit at [0]
    int          nbits;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  wr;
  logic [8:0]  din;
  logic [3:0]  full;
  logic [3:0]  busy;
  logic [3:0]  tx;
  uart_state_e st_a, st_b, st_c, st_d;

  int checks   = 0;
  int failures = 0;
  logic [0:0] exp_q[$];
  vec_t vecs[11];

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, got no end of test, required end of test");
    $fatal(1, "watchdog");
  end

  // ---------------- DUTs ----------------
  uart_tx_param #(.CLKS_PER_BIT(C)) dut_a (
    .i_clk(clk), .i_rst_n(rst_n), .i_wr(wr[0]), .i_data(din[7:0]),
    .o_full(full[0]), .o_busy(busy[0]), .o_uart_tx(tx[0]), .o_dbg_state(st_a));

  uart_tx_param #(.CLKS_PER_BIT(C), .PARITY(PARITY_EVEN)) dut_b (
    .i_clk(clk), .i_rst_n(rst_n), .i_wr(wr[1]), .i_data(din[7:0]),
    .o_full(full[1]), .o_busy(busy[1]), .o_uart_tx(tx[1]), .o_dbg_state(st_b));

  uart_tx_param #(.CLKS_PER_BIT(C), .PARITY(PARITY_ODD)) dut_c (
    .i_clk(clk), .i_rst_n(rst_n), .i_wr(wr[2]), .i_data(din[7:0]),
    .o_full(full[2]), .o_busy(busy[2]), .o_uart_tx(tx[2]), .o_dbg_state(st_c));

  uart_tx_param #(.CLKS_PER_BIT(C), .DATA_BITS(7), .STOP_BITS(2)) dut_d (
    .i_clk(clk), .i_rst_n(rst_n), .i_wr(wr[3]), .i_data(din[6:0]),
    .o_full(full[3]), .o_busy(busy[3]), .o_uart_tx(tx[3]), .o_dbg_state(st_d));

  // ---------------- scoreboard helper ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- driver: one word, whole frame checked ----------------
  task automatic send_frame(input int v, input int d, input logic [8:0] data,
                            input logic [12:0] frame, input int nbits);
    @(negedge clk);
    wr[d] = 1'b1;
    din   = data;
    @(posedge clk);               // edge N: word accepted
    #1;
    wr[d] = 1'b0;
    din   = ~data;                // later changes must not affect the word
    check($sformatf("vec%0d_busy_at_N", v), 32'(busy[d]), 32'd0);
    @(posedge clk);               // edge N+1
    #1;
    check($sformatf("vec%0d_busy_at_N1", v), 32'(busy[d]), 32'd1);
    check($sformatf("vec%0d_tx_at_N1", v), 32'(tx[d]), 32'd1);
    for (int i = 0; i < nbits; i++) begin
      for (int off = 0; off < C; off++) begin
        @(posedge clk);           // edge N+2+i*C+off
        #1;
        if (off == 0 || off == C - 1)
          check($sformatf("vec%0d_bit%0d_off%0d", v, i, off), 32'(tx[d]), 32'(frame[i]));
        if (i == nbits - 1 && off == C - 2)
          check($sformatf("vec%0d_busy_last", v), 32'(busy[d]), 32'd1);
        if (i == nbits - 1 && off == C - 1)
          check($sformatf("vec%0d_busy_end", v), 32'(busy[d]), 32'd0);
      end
    end
    @(posedge clk);
    #1;
    check($sformatf("vec%0d_idle_after", v), 32'(tx[d]), 32'd1);
  endtask

  // ---------------- test ----------------
  initial begin
    int low_cnt;
    int busy_cnt;
    logic [7:0] w;

    rst_n = 1'b0;
    wr    = '0;
    din   = '0;

    // Writes offered during reset must be ignored.
    wr[0] = 1'b1;
    din   = 9'h0AA;
    repeat (3) @(posedge clk);
    #1;
    check("rst_tx",    32'(tx),   32'hF);
    check("rst_busy",  32'(busy), 32'h0);
    check("rst_full",  32'(full), 32'h0);
    check("rst_state", 32'(st_a), 32'(ST_IDLE));
    @(negedge clk);
    rst_n = 1'b1;
    wr    = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_write_ignored_busy", 32'(busy[0]), 32'd0);
    check("rst_write_ignored_tx",   32'(tx[0]),   32'd1);

    // Table: {dut, data, frame bits (stop..data..start), frame length in bits}
    vecs[0]  = '{0, 9'h056, 13'b1_01010110_0,   10};
    vecs[1]  = '{0, 9'h000, 13'b1_00000000_0,   10};
    vecs[2]  = '{0, 9'h0FF, 13'b1_11111111_0,   10};
    vecs[3]  = '{0, 9'h0A5, 13'b1_10100101_0,   10};
    vecs[4]  = '{1, 9'h065, 13'b1_0_01100101_0, 11};
    vecs[5]  = '{2, 9'h065, 13'b1_1_01100101_0, 11};
    vecs[6]  = '{1, 9'h001, 13'b1_1_00000001_0, 11};
    vecs[7]  = '{2, 9'h0FF, 13'b1_1_11111111_0, 11};
    vecs[8]  = '{3, 9'h041, 13'b11_1000001_0,   10};
    vecs[9]  = '{3, 9'h02A, 13'b11_0101010_0,   10};
    vecs[10] = '{2, 9'h000, 13'b1_1_00000000_0, 11};

    for (int v = 0; v < 11; v++)
      send_frame(v, vecs[v].dut, vecs[v].data, vecs[v].frame, vecs[v].nbits);

    // ---- FIFO burst: 01..05 back to back, sixth write while full ----
    exp_q.delete();
    for (int k = 1; k <= 5; k++) begin
      w = 8'(k);
      exp_q.push_back(1'b0);
      for (int b = 0; b < 8; b++) exp_q.push_back(w[b]);
      exp_q.push_back(1'b1);
    end
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (k == 4) check("burst_full_at_3", 32'(full[0]), 32'd0);
      if (k == 5) check("burst_full_at_4", 32'(full[0]), 32'd1);
      wr[0] = 1'b1;
      din   = 9'(k + 1);
    end
    @(negedge clk);               // after edge N1+5: sixth write dropped
    wr[0] = 1'b0;
    check("burst_full_after_drop", 32'(full[0]), 32'd1);
    check("burst_start_bit", 32'(tx[0]), 32'd0);
    exp_q.pop_front();            // start bit of frame 1 already checked at c=3
    for (int c = 4; c < 200; c++) begin
      @(negedge clk);
      if (exp_q.size() == 0) begin
        check("burst_queue_underrun", 32'd1, 32'd0);
        break;
      end
      check($sformatf("burst_c%0d", c), 32'(tx[0]), 32'(exp_q[0]));
      if (c == 198) check("burst_busy_last", 32'(busy[0]), 32'd1);
      if (c == 199) check("burst_busy_end",  32'(busy[0]), 32'd0);
      if (c % C == C - 1) exp_q.pop_front();
    end
    low_cnt  = 0;
    busy_cnt = 0;
    repeat (60) begin
      @(negedge clk);
      if (tx[0] == 1'b0) low_cnt++;
      if (busy[0] == 1'b1) busy_cnt++;
    end
    check("burst_sixth_dropped_low",  32'(low_cnt),  32'd0);
    check("burst_sixth_dropped_busy", 32'(busy_cnt), 32'd0);

    // ---- reset mid-frame with two words queued ----
    @(negedge clk);
    wr[0] = 1'b1;
    din   = 9'h011;
    @(negedge clk);
    din   = 9'h022;
    @(negedge clk);
    din   = 9'h033;
    @(negedge clk);
    wr[0] = 1'b0;
    repeat (8) @(negedge clk);    // after edge N+10: second data bit on line
    check("midrst_state_pre", 32'(st_a),    32'(ST_DATA));
    check("midrst_busy_pre",  32'(busy[0]), 32'd1);
    check("midrst_tx_pre",    32'(tx[0]),   32'd0);
    rst_n = 1'b0;
    wr[0] = 1'b1;
    din   = 9'h044;
    @(posedge clk);
    #1;
    check("midrst_tx",    32'(tx[0]),   32'd1);
    check("midrst_busy",  32'(busy[0]), 32'd0);
    check("midrst_full",  32'(full[0]), 32'd0);
    check("midrst_state", 32'(st_a),    32'(ST_IDLE));
    @(negedge clk);
    rst_n = 1'b1;
    wr[0] = 1'b0;
    low_cnt  = 0;
    busy_cnt = 0;
    repeat (120) begin
      @(negedge clk);
      if (tx[0] == 1'b0) low_cnt++;
      if (busy[0] == 1'b1) busy_cnt++;
    end
    check("midrst_no_resume_low",  32'(low_cnt),  32'd0);
    check("midrst_no_resume_busy", 32'(busy_cnt), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
